cu_dispatch_arbiter: RTL

Schedules 16-bit instructions from the chip pins onto the two compute units (comp0, comp1) and returns their 8-bit results on one tagged result port, so results are no longer XOR/OR-merged at top level. It routes per-instruction (any / unit0 / unit1 / broadcast), tracks each unit's issue/busy/result state, and arbitrates result return round-robin. It sits between the pin-level input staging and the compute units inside tt_um_chipTop.

---
 rtl/cu_sched_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/cu_dispatch_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_sched_pkg.sv
`default_nettype none
// =============================================================================
// Module   : cu_sched_pkg
// Purpose  : Shared route codes, unit FSM encoding and result tags for the
//            compute-unit dispatch arbiter.
// Revision : 1.0 - initial release
// =============================================================================
package cu_sched_pkg;

    localparam logic [1:0] ROUTE_ANY = 2'b00;
    localparam logic [1:0] ROUTE_U0  = 2'b01;
    localparam logic [1:0] ROUTE_U1  = 2'b10;
    localparam logic [1:0] ROUTE_BC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_HOLD  = 2'd3
    } unit_state_t;

    localparam logic [1:0] TAG_U0 = 2'b01;
    localparam logic [1:0] TAG_U1 = 2'b10;
    localparam logic [1:0] TAG_BC = 2'b11;

    // Replicated across the result width to form the all-ones error result.
    localparam logic ERR_FILL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// =============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock valid/ready FIFO with registered full/empty flags.
// Revision : 1.0 - initial release
// =============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    assign push     = wr_valid & ~full_q;
    assign pop      = rd_ready & ~empty_q;
    assign wr_ready = ~full_q;
    assign rd_valid = ~empty_q;
    assign rd_data  = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/cu_dispatch_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : cu_dispatch_arbiter
// Purpose  : Routes FIFO-buffered instructions to two compute units and returns
//            their results round-robin on one tagged port. Optional per-unit
//            watchdog enabled by defining CU_WATCHDOG_EN.
// Revision : 1.0 - initial release
// =============================================================================
module cu_dispatch_arbiter
    import cu_sched_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 8,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               u0_valid,
    input  logic               u0_ready,
    output logic [INSTR_W-1:0] u0_instr,
    input  logic               u0_done,
    input  logic [DATA_W-1:0]  u0_result,
    output logic               u1_valid,
    input  logic               u1_ready,
    output logic [INSTR_W-1:0] u1_instr,
    input  logic               u1_done,
    input  logic [DATA_W-1:0]  u1_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [1:0]         res_unit,
    output logic               res_err
);
    logic               head_valid;
    logic [INSTR_W-1:0] head_instr;
    logic               head_pop;
    logic [1:0]         route;

    unit_state_t        st_q    [2];
    unit_state_t        st_d    [2];
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [DATA_W-1:0]  hold_q  [2];
    logic [DATA_W-1:0]  hold_d  [2];
    logic [DATA_W-1:0]  u_result [2];
    logic [1:0]         err_q, err_d;
    logic [1:0]         u_ready, u_done, idle, holding, issue, grant;

    logic               disp_rr_q, disp_rr_d;
    logic               res_rr_q, res_rr_d;
    logic               bc_pending_q, bc_pending_d;
    logic               bc_set, bc_clr, load_ok;

    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic [1:0]         res_unit_q, res_unit_d;
    logic               res_err_q, res_err_d;

`ifdef CU_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    wd_q [2];
    logic [WD_W-1:0]    wd_d [2];
`endif

    sync_fifo #(.WIDTH(INSTR_W), .DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (in_instr),
        .rd_valid (head_valid),
        .rd_ready (head_pop),
        .rd_data  (head_instr)
    );

    assign route       = head_instr[INSTR_W-1 -: 2];
    assign u_ready     = {u1_ready, u0_ready};
    assign u_done      = {u1_done, u0_done};
    assign u_result[0] = u0_result;
    assign u_result[1] = u1_result;
    assign idle        = {st_q[1] == ST_IDLE, st_q[0] == ST_IDLE};
    assign holding     = {st_q[1] == ST_HOLD, st_q[0] == ST_HOLD};
    assign head_pop    = |issue;
    assign load_ok     = ~res_valid_q | res_ready;

    assign u0_valid  = (st_q[0] == ST_ISSUE);
    assign u1_valid  = (st_q[1] == ST_ISSUE);
    assign u0_instr  = instr_q[0];
    assign u1_instr  = instr_q[1];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_unit  = res_unit_q;
    assign res_err   = res_err_q;

    // Dispatch of the FIFO head; a pending broadcast freezes all dispatch.
    always_comb begin
        issue     = 2'b00;
        disp_rr_d = disp_rr_q;
        bc_set    = 1'b0;
        if (head_valid && !bc_pending_q) begin
            case (route)
                ROUTE_U0: issue[0] = idle[0];
                ROUTE_U1: issue[1] = idle[1];
                ROUTE_BC: begin
                    if (&idle) begin
                        issue  = 2'b11;
                        bc_set = 1'b1;
                    end
                end
                default: begin
                    if (idle[disp_rr_q]) begin
                        issue[disp_rr_q] = 1'b1;
                        disp_rr_d        = ~disp_rr_q;
                    end else if (idle[~disp_rr_q]) begin
                        issue[~disp_rr_q] = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        grant    = 2'b00;
        res_rr_d = res_rr_q;
        bc_clr   = 1'b0;
        if (load_ok) begin
            if (bc_pending_q) begin
                if (&holding) begin
                    grant  = 2'b11;
                    bc_clr = 1'b1;
                end
            end else if (&holding) begin
                grant[res_rr_q] = 1'b1;
                res_rr_d        = ~res_rr_q;
            end else begin
                grant = holding;
            end
        end

        res_valid_d = (res_valid_q & ~res_ready) | (|grant);
        res_data_d  = res_data_q;
        res_unit_d  = res_unit_q;
        res_err_d   = res_err_q;
        if (grant == 2'b11) begin
            res_data_d = hold_q[0] ^ hold_q[1];
            res_unit_d = TAG_BC;
            res_err_d  = |err_q;
        end else if (grant[0]) begin
            res_data_d = hold_q[0];
            res_unit_d = TAG_U0;
            res_err_d  = err_q[0];
        end else if (grant[1]) begin
            res_data_d = hold_q[1];
            res_unit_d = TAG_U1;
            res_err_d  = err_q[1];
        end

        bc_pending_d = bc_set | (bc_pending_q & ~bc_clr);
    end

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < 2; i++) begin
            st_d[i]    = st_q[i];
            instr_d[i] = instr_q[i];
            hold_d[i]  = hold_q[i];
`ifdef CU_WATCHDOG_EN
            wd_d[i]    = wd_q[i];
`endif
            case (st_q[i])
                ST_IDLE: begin
                    if (issue[i]) begin
                        st_d[i]    = ST_ISSUE;
                        instr_d[i] = head_instr;
                    end
                end
                ST_ISSUE: begin
                    if (u_ready[i]) begin
                        st_d[i] = ST_BUSY;
`ifdef CU_WATCHDOG_EN
                        wd_d[i] = '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (u_done[i]) begin
                        st_d[i]   = ST_HOLD;
                        hold_d[i] = u_result[i];
                        err_d[i]  = 1'b0;
                    end
`ifdef CU_WATCHDOG_EN
                    else if (wd_q[i] == WD_W'(TIMEOUT - 1)) begin
                        st_d[i]   = ST_HOLD;
                        hold_d[i] = {DATA_W{ERR_FILL}};
                        err_d[i]  = 1'b1;
                    end else begin
                        wd_d[i] = wd_q[i] + 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (grant[i]) st_d[i] = ST_IDLE;
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]    <= ST_IDLE;
                instr_q[i] <= '0;
                hold_q[i]  <= '0;
`ifdef CU_WATCHDOG_EN
                wd_q[i]    <= '0;
`endif
            end
            err_q        <= 2'b00;
            disp_rr_q    <= 1'b0;
            res_rr_q     <= 1'b0;
            bc_pending_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_unit_q   <= 2'b00;
            res_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]    <= st_d[i];
                instr_q[i] <= instr_d[i];
                hold_q[i]  <= hold_d[i];
`ifdef CU_WATCHDOG_EN
                wd_q[i]    <= wd_d[i];
`endif
            end
            err_q        <= err_d;
            disp_rr_q    <= disp_rr_d;
            res_rr_q     <= res_rr_d;
            bc_pending_q <= bc_pending_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_unit_q   <= res_unit_d;
            res_err_q    <= res_err_d;
        end
    end

endmodule
`default_nettype wire
